uart_tx_frame: RTL and testbench

Serial transmitter for the UART path. It accepts a parallel byte with a valid strobe and serialises it onto a single line, one bit per `CLK` cycle, in the frame the receive-side checkers expect:

- a start bit (0)
- `DATA_WIDTH` data bits, LSB first
- an optional parity bit
- one stop bit (1)

`CLK` is the TX bit clock; baud-rate division happens upstream.

---
 rtl/uart_tx_frame_if.sv | 47 ++++
 rtl/uart_tx_frame.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_if
// Groups the parallel request side and the serial/status side of the UART
// frame transmitter into one bundle.
//
//   P_DATA      parallel byte to send
//   Data_Valid  request strobe (single cycle or held)
//   PAR_EN      1 = append a parity bit after the data bits
//   PAR_TYP     0 = even parity, 1 = odd parity
//   TX_OUT      serial line, idles high
//   busy        high from start bit through stop bit
//   hold_full   one-entry holding register occupied
//
// master : the requester (drives the byte and strobe, observes the line)
// slave  : the transmitter
// ---------------------------------------------------------------------------
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;
  logic                  hold_full;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  busy,
    input  hold_full
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output busy,
    output hold_full
  );
endinterface

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Serialises one parallel word per request onto a single line, one bit per
// CLK cycle: start bit (0), DATA_WIDTH data bits LSB first, optional parity
// bit, one stop bit (1). CLK is already the bit clock.
//
// Ports:
//   CLK  in   bit clock, all state changes on its rising edge
//   RST  in   synchronous active-low reset
//   bus  slave modport of uart_tx_frame_if (P_DATA, Data_Valid, PAR_EN,
//        PAR_TYP in; TX_OUT, busy, hold_full out)
//
// Optional feature, macro UART_TX_HOLD_REG_EN:
//   defined   - a one-entry holding register accepts a request while a frame
//               is in flight; it is launched back-to-back after the stop bit.
//   undefined - requests while busy are dropped and hold_full is constant 0.
// ---------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_frame_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity is resolved when the word is latched, because the shift register
  // no longer holds the data by the time the parity bit is sent.
  function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] data,
                                        input logic                  odd);
    frame_parity = (^data) ^ odd;
  endfunction

  state_t                r_state;
  logic                  r_tx;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic                  r_par_en;
  logic                  r_par_bit;

  state_t                w_state;
  logic                  w_tx;
  logic                  w_busy;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [CW-1:0]         w_cnt;
  logic                  w_par_en;
  logic                  w_par_bit;

`ifdef UART_TX_HOLD_REG_EN
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_par_en;
  logic                  r_hold_par_bit;
  logic                  r_hold_full;

  logic [DATA_WIDTH-1:0] w_hold_data;
  logic                  w_hold_par_en;
  logic                  w_hold_par_bit;
  logic                  w_hold_full;
  logic                  w_take_hold;
`endif

  // Next-state, next-output and datapath update for the frame FSM.
  always_comb begin
    w_state   = r_state;
    w_tx      = r_tx;
    w_busy    = r_busy;
    w_shift   = r_shift;
    w_cnt     = r_cnt;
    w_par_en  = r_par_en;
    w_par_bit = r_par_bit;
`ifdef UART_TX_HOLD_REG_EN
    w_take_hold = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        w_tx   = 1'b1;
        w_busy = 1'b0;
`ifdef UART_TX_HOLD_REG_EN
        // A word loaded on the final stop edge lands here; it wins over a
        // fresh request so nothing already accepted is lost.
        if (r_hold_full) begin
          w_take_hold = 1'b1;
          w_state     = S_START;
          w_tx        = 1'b0;
          w_busy      = 1'b1;
          w_shift     = r_hold_data;
          w_par_en    = r_hold_par_en;
          w_par_bit   = r_hold_par_bit;
        end else if (bus.Data_Valid) begin
`else
        if (bus.Data_Valid) begin
`endif
          w_state   = S_START;
          w_tx      = 1'b0;
          w_busy    = 1'b1;
          w_shift   = bus.P_DATA;
          w_par_en  = bus.PAR_EN;
          w_par_bit = frame_parity(bus.P_DATA, bus.PAR_TYP);
        end else begin
          w_state = S_IDLE;
        end
      end

      S_START: begin
        // Start bit is on the line; present data bit 0 next.
        w_state = S_DATA;
        w_tx    = r_shift[0];
        w_shift = r_shift >> 1;
        w_cnt   = {CW{1'b0}};
        w_busy  = 1'b1;
      end

      S_DATA: begin
        w_busy = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_cnt = {CW{1'b0}};
          if (r_par_en) begin
            w_state = S_PARITY;
            w_tx    = r_par_bit;
          end else begin
            w_state = S_STOP;
            w_tx    = 1'b1;
          end
        end else begin
          w_tx    = r_shift[0];
          w_shift = r_shift >> 1;
          w_cnt   = r_cnt + CW'(1);
        end
      end

      S_PARITY: begin
        w_state = S_STOP;
        w_tx    = 1'b1;
        w_busy  = 1'b1;
      end

      S_STOP: begin
`ifdef UART_TX_HOLD_REG_EN
        if (r_hold_full) begin
          // Back-to-back hand-off: no idle cycle between frames.
          w_take_hold = 1'b1;
          w_state     = S_START;
          w_tx        = 1'b0;
          w_busy      = 1'b1;
          w_shift     = r_hold_data;
          w_par_en    = r_hold_par_en;
          w_par_bit   = r_hold_par_bit;
        end else begin
          w_state = S_IDLE;
          w_tx    = 1'b1;
          w_busy  = 1'b0;
        end
`else
        w_state = S_IDLE;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
`endif
      end

      default: begin
        w_state = S_IDLE;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
        w_cnt   = {CW{1'b0}};
        w_shift = {DATA_WIDTH{1'b0}};
      end
    endcase

`ifdef UART_TX_HOLD_REG_EN
    w_hold_data    = r_hold_data;
    w_hold_par_en  = r_hold_par_en;
    w_hold_par_bit = r_hold_par_bit;
    w_hold_full    = r_hold_full;
    // A hand-off only happens with the register full, so a request on that
    // edge is dropped by the full check below as well.
    if (w_take_hold) begin
      w_hold_full = 1'b0;
    end else if (r_busy && !r_hold_full && bus.Data_Valid) begin
      w_hold_data    = bus.P_DATA;
      w_hold_par_en  = bus.PAR_EN;
      w_hold_par_bit = frame_parity(bus.P_DATA, bus.PAR_TYP);
      w_hold_full    = 1'b1;
    end else begin
      w_hold_full = r_hold_full;
    end
`endif
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_shift   <= {DATA_WIDTH{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_tx      <= w_tx;
      r_busy    <= w_busy;
      r_shift   <= w_shift;
      r_cnt     <= w_cnt;
      r_par_en  <= w_par_en;
      r_par_bit <= w_par_bit;
    end
  end

`ifdef UART_TX_HOLD_REG_EN
  // Holding register for one request accepted during a frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_hold_data    <= {DATA_WIDTH{1'b0}};
      r_hold_par_en  <= 1'b0;
      r_hold_par_bit <= 1'b0;
      r_hold_full    <= 1'b0;
    end else begin
      r_hold_data    <= w_hold_data;
      r_hold_par_en  <= w_hold_par_en;
      r_hold_par_bit <= w_hold_par_bit;
      r_hold_full    <= w_hold_full;
    end
  end

  assign bus.hold_full = r_hold_full;
`else
  assign bus.hold_full = 1'b0;
`endif

  assign bus.TX_OUT = r_tx;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
// Table of directed frames with hand-computed line sequences, hand-written
// corner sequences (mid-frame input changes, request while busy, reset
// mid-frame), and randomized frames checked against a frame-building model.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

  logic CLK;
  logic RST;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks;
  int n_passed;

  // Expected line bits of the current stimulus, first bit first.
  bit exp_q[$];
  // Window (line-bit index, end exclusive) in which hold_full must be 1.
  int hold_from;
  int hold_to;

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic [11:0] bits;   // frame written first-bit-leftmost in its low len bits
    int          len;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      n_passed++;
    end
  endtask

  // Reference frame: start, data LSB first, optional parity from the
  // count of ones, stop.
  task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt);
    int ones;
    ones = $countones(d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) begin
      if (pt) exp_q.push_back((ones % 2) == 0);
      else    exp_q.push_back((ones % 2) == 1);
    end
    exp_q.push_back(1'b1);
  endtask

  // Issue one request and follow the line for exp_q.size() cycles.
  // Called at #1 after an edge with the DUT idle.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input bit wiggle, input int pulse_at, input string nm);
    int len;
    len = exp_q.size();
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
    @(posedge CLK); #1;
    bus.Data_Valid = 1'b0;
    for (int n = 0; n < len; n++) begin
      chk($sformatf("%s bit%0d", nm, n), 32'(bus.TX_OUT), 32'(exp_q[n]));
      chk($sformatf("%s busy%0d", nm, n), 32'(bus.busy), 32'd1);
      chk($sformatf("%s hold%0d", nm, n), 32'(bus.hold_full),
          32'((n >= hold_from) && (n < hold_to)));
      if (wiggle) begin
        bus.P_DATA  = ~bus.P_DATA;
        bus.PAR_TYP = ~bus.PAR_TYP;
        bus.PAR_EN  = $urandom_range(1, 0);
      end
      if (n == pulse_at) begin
        bus.P_DATA     = 8'h3C;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Data_Valid = 1'b1;
      end else begin
        bus.Data_Valid = 1'b0;
      end
      @(posedge CLK); #1;
    end
    chk($sformatf("%s end_tx", nm), 32'(bus.TX_OUT), 32'd1);
    chk($sformatf("%s end_busy", nm), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int bad;
    n_checks  = 0;
    n_passed  = 0;
    hold_from = 0;
    hold_to   = 0;
    RST            = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 12'(10'b0101001011),  10};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 12'(11'b01010010101), 11};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 12'(11'b01010010111), 11};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 12'(11'b01000000001), 11};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 12'(11'b00000000001), 11};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 12'(11'b01111111111), 11};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 12'(10'b0111111111),  10};
    vecs[7] = '{8'h5A, 1'b0, 1'b0, 12'(10'b0010110101),  10};
    vecs[8] = '{8'h80, 1'b1, 1'b0, 12'(11'b00000000111), 11};

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst tx", 32'(bus.TX_OUT), 32'd1);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst hold", 32'(bus.hold_full), 32'd0);
    RST = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    chk("idle after reset", 32'(bad), 32'd0);

    // Directed table.
    for (int v = 0; v < 9; v++) begin
      exp_q.delete();
      for (int n = 0; n < vecs[v].len; n++)
        exp_q.push_back(vecs[v].bits[vecs[v].len - 1 - n]);
      run_frame(vecs[v].data, vecs[v].pe, vecs[v].pt, 1'b0, -1, $sformatf("vec%0d", v));
    end

    // Odd parity with inputs toggling throughout the frame.
    exp_q.delete();
    build_frame(8'h01, 1'b1, 1'b1);
    run_frame(8'h01, 1'b1, 1'b1, 1'b1, -1, "wiggle");
    bus.PAR_EN = 1'b0;
    @(posedge CLK); #1;

    // Request while busy.
    exp_q.delete();
    build_frame(8'hA5, 1'b0, 1'b0);
`ifdef UART_TX_HOLD_REG_EN
    build_frame(8'h3C, 1'b0, 1'b0);
    hold_from = 3;
    hold_to   = 10;
`endif
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 2, "busyreq");
    hold_from = 0;
    hold_to   = 0;
    bad = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 || bus.hold_full !== 1'b0) bad++;
    end
    chk("busyreq quiet after", 32'(bad), 32'd0);

    // Reset on the 4th data bit.
    bus.P_DATA     = 8'h5A;
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b1;
    @(posedge CLK); #1;
    bus.Data_Valid = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
    end
    chk("midrst bit3", 32'(bus.TX_OUT), 32'd1);
    chk("midrst busy before", 32'(bus.busy), 32'd1);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("midrst tx", 32'(bus.TX_OUT), 32'd1);
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst hold", 32'(bus.hold_full), 32'd0);
    RST = 1'b1;
    bad = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    chk("midrst no resume", 32'(bad), 32'd0);
    exp_q.delete();
    build_frame(8'h5A, 1'b0, 1'b0);
    run_frame(8'h5A, 1'b0, 1'b0, 1'b0, -1, "after_rst");

    // Randomized frames with random gaps.
    for (int r = 0; r < 40; r++) begin
      logic [7:0] d;
      logic       pe;
      logic       pt;
      bit         wg;
      d  = 8'($urandom);
      pe = 1'($urandom_range(1, 0));
      pt = 1'($urandom_range(1, 0));
      wg = 1'($urandom_range(1, 0));
      exp_q.delete();
      build_frame(d, pe, pt);
      run_frame(d, pe, pt, wg, -1, $sformatf("rnd%0d", r));
      repeat ($urandom_range(3, 0)) begin
        @(posedge CLK); #1;
      end
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
